// File: rtl/cam_pattern_pkg.sv
// rtl/cam_pattern_pkg.sv - shared types, default timing and LFSR constants for cam_pattern_gen
// Contents: state_t (IDLE/RUN), default raster timing, LFSR seed/taps,
//           in_span() helper for the 17-bit blob bounds test.
package cam_pattern_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 160;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_BLANK  = 45;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_PIX_W    = 12;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // pos in [start, start+len); 17 bits so start+len cannot wrap
    function automatic logic in_span(input logic [16:0] pos,
                                     input logic [16:0] start,
                                     input logic [16:0] len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/cam_pattern_gen_if.sv
// rtl/cam_pattern_gen_if.sv - parallel camera video bus
// Signals: PIXEL_CLK, LINE_VALID, FRAME_VALID, PIXEL_DATA[PIX_W-1:0]
// master drives the bus (pattern source), slave samples on PIXEL_CLK rise.
interface cam_pattern_gen_if #(
    parameter int PIX_W = 12
);
    logic             PIXEL_CLK;
    logic             LINE_VALID;
    logic             FRAME_VALID;
    logic [PIX_W-1:0] PIXEL_DATA;

    modport master (output PIXEL_CLK, output LINE_VALID, output FRAME_VALID, output PIXEL_DATA);
    modport slave  (input  PIXEL_CLK, input  LINE_VALID, input  FRAME_VALID, input  PIXEL_DATA);
endinterface

// File: rtl/cam_pattern_lfsr.sv
// rtl/cam_pattern_lfsr.sv - 16-bit Fibonacci LFSR for background noise
// Ports: clk, resetn (sync, active-low, loads seed), step (advance one state),
//        lfsr_state[15:0] current state.
module cam_pattern_lfsr
    import cam_pattern_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        step,
    output logic [15:0] lfsr_state
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_state <= LFSR_SEED;
        end else if (step) begin
            lfsr_state <= {lfsr_state[14:0], ^(lfsr_state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - synthetic camera source: flat background plus one square blob
// Ports: clk_clk, reset_reset_n (sync, active-low), enable (sampled at frame boundary),
//        blob_x/blob_y/blob_size, fg_level/bg_level (shadowed per frame),
//        video (cam_pattern_gen_if.master), frame_done (1-clk pulse at frame end).
// Optional: define CAM_PATTERN_NOISE_EN to XOR LFSR noise into background bits 3:0.
module cam_pattern_gen
    import cam_pattern_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int PIX_W    = DEF_PIX_W
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             enable,
    input  logic [15:0]      blob_x,
    input  logic [15:0]      blob_y,
    input  logic [7:0]       blob_size,
    input  logic [PIX_W-1:0] fg_level,
    input  logic [PIX_W-1:0] bg_level,
    cam_pattern_gen_if.master video,
    output logic             frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [15:0]      sh_x;
    logic [15:0]      sh_y;
    logic [7:0]       sh_size;
    logic [PIX_W-1:0] sh_fg;
    logic [PIX_W-1:0] sh_bg;
    logic             pclk_q;
    logic             lv_q;
    logic             fv_q;
    logic [PIX_W-1:0] data_q;

    logic             pix_ce;
    logic             h_last;
    logic             v_last;
    logic             act_fv;
    logic             act_lv;
    logic             in_blob;
    logic [PIX_W-1:0] bg_pix;
    logic [PIX_W-1:0] data_next;

    assign pix_ce  = (state == RUN) && (div_cnt == DW'(CLK_DIV - 1));
    assign h_last  = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last  = (v_cnt == VW'(V_TOTAL - 1));
    assign act_fv  = (v_cnt < VW'(V_ACTIVE));
    assign act_lv  = act_fv && (h_cnt < HW'(H_ACTIVE));
    // Gating with act_lv clips the blob at the active-area edges
    assign in_blob = act_lv
                   && in_span(17'(h_cnt), 17'(sh_x), 17'(sh_size))
                   && in_span(17'(v_cnt), 17'(sh_y), 17'(sh_size));

`ifdef CAM_PATTERN_NOISE_EN
    logic [15:0] lfsr_state;

    cam_pattern_lfsr u_lfsr (
        .clk        (clk_clk),
        .resetn     (reset_reset_n),
        .step       (pix_ce),
        .lfsr_state (lfsr_state)
    );

    assign bg_pix = sh_bg ^ {{(PIX_W-4){1'b0}}, lfsr_state[3:0]};
`else
    assign bg_pix = sh_bg;
`endif

    assign data_next = in_blob ? sh_fg : (act_lv ? bg_pix : '0);

    // PIXEL_CLK is registered from the next div_cnt value so that it equals
    // (div_cnt >= CLK_DIV/2) of the current cycle without a combinational output.
    always_ff @(posedge clk_clk) begin
        frame_done <= 1'b0;
        if (!reset_reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            sh_x    <= '0;
            sh_y    <= '0;
            sh_size <= '0;
            sh_fg   <= '0;
            sh_bg   <= '0;
            pclk_q  <= 1'b0;
            lv_q    <= 1'b0;
            fv_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    h_cnt   <= '0;
                    v_cnt   <= '0;
                    pclk_q  <= 1'b0;
                    lv_q    <= 1'b0;
                    fv_q    <= 1'b0;
                    data_q  <= '0;
                    if (enable) begin
                        sh_x    <= blob_x;
                        sh_y    <= blob_y;
                        sh_size <= blob_size;
                        sh_fg   <= fg_level;
                        sh_bg   <= bg_level;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (pix_ce) begin
                        div_cnt <= '0;
                        pclk_q  <= 1'b0;
                        fv_q    <= act_fv;
                        lv_q    <= act_lv;
                        data_q  <= data_next;
                        if (h_last) begin
                            h_cnt <= '0;
                            if (v_last) begin
                                v_cnt      <= '0;
                                frame_done <= 1'b1;
                                if (enable) begin
                                    sh_x    <= blob_x;
                                    sh_y    <= blob_y;
                                    sh_size <= blob_size;
                                    sh_fg   <= fg_level;
                                    sh_bg   <= bg_level;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                v_cnt <= v_cnt + 1'b1;
                            end
                        end else begin
                            h_cnt <= h_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        pclk_q  <= (DW'(div_cnt + 1'b1) >= DW'(CLK_DIV / 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign video.PIXEL_CLK   = pclk_q;
    assign video.LINE_VALID  = lv_q;
    assign video.FRAME_VALID = fv_q;
    assign video.PIXEL_DATA  = data_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb/tb_cam_pattern_gen.sv - self-checking bench for cam_pattern_gen (8x6 active, 4/2 blank, div 2)
module tb_cam_pattern_gen;

    localparam int HA   = 8;
    localparam int HB   = 4;
    localparam int VA   = 6;
    localparam int VB   = 2;
    localparam int HT   = HA + HB;
    localparam int VT   = VA + VB;
    localparam int NPIX = HT * VT;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] blob_x;
    logic [15:0] blob_y;
    logic [7:0]  blob_size;
    logic [11:0] fg_level;
    logic [11:0] bg_level;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic        pr_lv;
    logic        pr_fv;
    logic [11:0] pr_d;

`ifdef CAM_PATTERN_NOISE_EN
    logic [15:0] lfsr_m;
`endif

    cam_pattern_gen_if #(.PIX_W(12)) video ();

    cam_pattern_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .CLK_DIV  (2),
        .PIX_W    (12)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (resetn),
        .enable        (enable),
        .blob_x        (blob_x),
        .blob_y        (blob_y),
        .blob_size     (blob_size),
        .fg_level      (fg_level),
        .bg_level      (bg_level),
        .video         (video),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_lfsr();
`ifdef CAM_PATTERN_NOISE_EN
        lfsr_m = 16'hACE1;
`endif
    endtask

    task automatic step_lfsr();
`ifdef CAM_PATTERN_NOISE_EN
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
    endtask

    function automatic logic [3:0] cur_noise();
`ifdef CAM_PATTERN_NOISE_EN
        return lfsr_m[3:0];
`else
        return 4'h0;
`endif
    endfunction

    // Expected pixel from raster position and the frame's latched settings
    function automatic logic [11:0] exp_data(input int x, input int y, input int bx, input int by,
                                             input int sz, input logic [11:0] fg,
                                             input logic [11:0] bg, input logic [3:0] noise);
        bit lv;
        lv = (y < VA) && (x < HA);
        if (lv && x >= bx && x < bx + sz && y >= by && y < by + sz) return fg;
        if (lv) return bg ^ {8'h00, noise};
        return 12'h000;
    endfunction

    // Returns at the first sample (negedge) where PIXEL_CLK has risen; pr_* hold the sample before it
    task automatic wait_rise(output bit ok, output int n);
        logic p;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            p     = video.PIXEL_CLK;
            pr_lv = video.LINE_VALID;
            pr_fv = video.FRAME_VALID;
            pr_d  = video.PIXEL_DATA;
            @(negedge clk);
            n++;
            if (video.PIXEL_CLK === 1'b1 && p === 1'b0) ok = 1'b1;
        end
        if (!ok) chk("rise_timeout", 0, 1);
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_pclk", video.PIXEL_CLK, 0);
            chk("idle_lv", video.LINE_VALID, 0);
            chk("idle_fv", video.FRAME_VALID, 0);
            chk("idle_data", video.PIXEL_DATA, 0);
            chk("idle_frame_done", frame_done, 0);
        end
    endtask

    // First PIXEL_CLK rise after IDLE->RUN precedes the first pixel
    task automatic start_run();
        bit ok;
        int n;
        enable = 1'b1;
        wait_rise(ok, n);
        chk("start_period", n, 2);
        chk("start_fv", video.FRAME_VALID, 0);
        chk("start_lv", video.LINE_VALID, 0);
        chk("start_data", video.PIXEL_DATA, 0);
    endtask

    task automatic check_frame(input int chg_at, input int nx, input int ny, input int nsz,
                               input logic [11:0] nfg, input logic [11:0] nbg, input int drop_at);
        int bx, by, sz, x, y, n;
        logic [11:0] fg, bg, ed;
        bit ok, efv, elv;
        bx = blob_x; by = blob_y; sz = blob_size; fg = fg_level; bg = bg_level;
        for (int p = 0; p < NPIX - 1; p++) begin
            wait_rise(ok, n);
            x   = p % HT;
            y   = p / HT;
            efv = (y < VA);
            elv = efv && (x < HA);
            ed  = exp_data(x, y, bx, by, sz, fg, bg, cur_noise());
            chk("pclk_period", n, 2);
            chk("fv_pre_rise", pr_fv, efv);
            chk("lv_pre_rise", pr_lv, elv);
            chk("data_pre_rise", pr_d, ed);
            chk("fv", video.FRAME_VALID, efv);
            chk("lv", video.LINE_VALID, elv);
            chk("data", video.PIXEL_DATA, ed);
            chk("frame_done_mid", frame_done, 0);
            step_lfsr();
            if (p == chg_at) begin
                blob_x = 16'(nx); blob_y = 16'(ny); blob_size = 8'(nsz);
                fg_level = nfg; bg_level = nbg;
            end
            if (p == drop_at) enable = 1'b0;
        end
        step_lfsr();
        @(negedge clk);
        chk("frame_done", frame_done, 1);
        chk("end_fv", video.FRAME_VALID, 0);
        chk("end_lv", video.LINE_VALID, 0);
        chk("end_data", video.PIXEL_DATA, 0);
        @(negedge clk);
        chk("frame_done_width", frame_done, 0);
        chk("pclk_after_frame", video.PIXEL_CLK, enable);
        chk("after_fv", video.FRAME_VALID, 0);
        chk("after_data", video.PIXEL_DATA, 0);
    endtask

    initial begin
        bit ok;
        int n, rx, ry, rs;
        logic [11:0] rbg;
        resetn = 1'b0; enable = 1'b0;
        blob_x = 16'd0; blob_y = 16'd0; blob_size = 8'd0;
        fg_level = 12'h000; bg_level = 12'h000;
        reset_lfsr();
        repeat (3) @(negedge clk);
        chk("rst_pclk", video.PIXEL_CLK, 0);
        chk("rst_lv", video.LINE_VALID, 0);
        chk("rst_fv", video.FRAME_VALID, 0);
        chk("rst_data", video.PIXEL_DATA, 0);
        chk("rst_frame_done", frame_done, 0);
        resetn = 1'b1;
        check_idle(3);

        // Frame 0: blob 2,1,3; blob_x moves to 5 at row 2 and must only affect frame 1
        blob_x = 16'd2; blob_y = 16'd1; blob_size = 8'd3;
        fg_level = 12'hFFF; bg_level = 12'h010;
        start_run();
        check_frame(2 * HT, 5, 1, 3, 12'hFFF, 12'h010, -1);
        // Frame 1: blob at x 5..7; next frame clipped blob 6,4,5
        check_frame(60, 6, 4, 5, 12'hFFF, 12'h010, -1);
        // Frame 2: clipped to x 6..7, y 4..5; next frame has no blob
        check_frame(60, 3, 3, 0, 12'hFFF, 12'h010, -1);
        // Frame 3: blob_size 0
        rx = $urandom_range(0, 10); ry = $urandom_range(0, 9); rs = $urandom_range(0, 7);
        rbg = 12'($urandom_range(0, 12'h7FF));
        check_frame(60, rx, ry, rs, 12'hFFF, rbg, -1);

        // Randomized frames, last one drops enable mid-frame
        for (int f = 0; f < 5; f++) begin
            rx = $urandom_range(0, 10); ry = $urandom_range(0, 9); rs = $urandom_range(0, 7);
            rbg = 12'($urandom_range(0, 12'h7FF));
            check_frame($urandom_range(0, NPIX - 2), rx, ry, rs, 12'hFFF, rbg,
                        (f == 4) ? 40 : -1);
        end
        check_idle(6);

        // Reset in the middle of an active line
        blob_x = 16'd0; blob_y = 16'd0; blob_size = 8'd4;
        fg_level = 12'hFFF; bg_level = 12'h030;
        start_run();
        for (int k = 0; k < 14; k++) wait_rise(ok, n);
        chk("pre_reset_lv", video.LINE_VALID, 1);
        resetn = 1'b0;
        enable = 1'b0;
        check_idle(4);
        reset_lfsr();
        resetn = 1'b1;
        check_idle(2);

        // Fresh frame after reset: noise sequence restarts from the seed
        blob_x = 16'd1; blob_y = 16'd2; blob_size = 8'd4;
        fg_level = 12'hFFF; bg_level = 12'h020;
        start_run();
        check_frame(-1, 0, 0, 0, 12'h000, 12'h000, 0);
        check_idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
